// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared width, iteration count, FSM encoding and magnitude helper for mult_div.
package mult_div_pkg;
  localparam int WIDTH = 32;
  localparam int ITERATIONS = 32;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction
endpackage

// File: rtl/mult_div_addsub33.sv
// addsub33: 33-bit combinational adder/subtractor shared by multiply-add and divide trial-subtract.
module addsub33 (
  input  logic [32:0] i_a,
  input  logic [32:0] i_b,
  input  logic        i_sub,
  output logic [32:0] o_sum
);
  assign o_sum = i_sub ? i_a - i_b : i_a + i_b;
endmodule

// File: rtl/mult_div.sv
// mult_div: iterative signed 32-bit multiply (low word) and divide (quotient), 33-cycle latency.
module mult_div import mult_div_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);
  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_m;
  logic        r_neg;
  logic        w_mul, w_start, w_ge, w_dz, w_exc;
  logic [32:0] w_a, w_sum, w_t;
  logic [63:0] w_next, w_prod;
  logic [31:0] w_quo, w_res;

  assign busy = r_state == MULT || r_state == DIV;
  assign result_rdy = r_state == DONE;
  assign w_mul = r_state == MULT;
  assign w_start = (ctrl_mult || ctrl_div) && !busy;
  // multiply: r_acc = {partial sum, multiplier}; divide: r_acc = {remainder, dividend -> quotient}
  assign w_a = w_mul ? {1'b0, r_acc[63:32]} : r_acc[63:31];
  addsub33 u_addsub (
    .i_a  (w_a),
    .i_b  ({1'b0, r_m}),
    .i_sub(!w_mul),
    .o_sum(w_sum)
  );
  assign w_ge = !w_sum[32];
  assign w_t = r_acc[0] ? w_sum : {1'b0, r_acc[63:32]};
  assign w_next = w_mul ? {w_t, r_acc[31:1]} : {w_ge ? w_sum[31:0] : w_a[31:0], r_acc[30:0], w_ge};
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo = r_neg ? -r_acc[31:0] : r_acc[31:0];
  assign w_dz = r_m == '0;
  assign w_res = w_mul ? w_prod[31:0] : (w_dz ? '0 : w_quo);
  assign w_exc = w_mul ? r_acc > (r_neg ? 64'h8000_0000 : 64'h7fff_ffff) : w_dz || (!r_neg && r_acc[31]);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_acc <= '0;
      r_m <= '0;
      r_neg <= 1'b0;
      result <= '0;
      exception <= 1'b0;
    end else if (w_start) begin
      r_state <= ctrl_mult ? MULT : DIV;
      r_cnt <= '0;
      r_acc <= {32'd0, mag(ctrl_mult ? operand_b : operand_a)};
      r_m <= mag(ctrl_mult ? operand_a : operand_b);
      r_neg <= operand_a[31] ^ operand_b[31];
    end else if (busy) begin
      if (r_cnt != 6'(ITERATIONS)) begin
        r_cnt <= r_cnt + 6'd1;
        r_acc <= w_next;
      end else begin
        r_state <= DONE;
        result <= w_res;
        exception <= w_exc;
      end
    end else begin
      r_state <= IDLE;
    end
  end
endmodule
